module_debouncer_multi: RTL and testbench

Parametrised multi-channel debouncer for push-buttons and switches. Each channel has its own synchroniser chain and stability counter, plus registered rise/fall event pulses. An optional sample tick lets a shared prescaler stretch the debounce window without widening counters. Sits between board pins and control FSMs, e.g. the SPI mode/trigger inputs.

---
 rtl/debouncer_pkg.sv | 7 +
 rtl/module_debouncer_channel.sv | 80 ++++++++
 rtl/module_debouncer_multi.sv | 45 ++++
 tb/tb_module_debouncer_multi.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/debouncer_pkg.sv
// rtl/debouncer_pkg.sv - default constants shared by the debouncer modules
package debouncer_pkg;

    localparam int DEB_SYNC_STAGES_DEF   = 2;
    localparam int DEB_STABLE_CYCLES_DEF = 1000;

endpackage

// File: rtl/module_debouncer_channel.sv
// rtl/module_debouncer_channel.sv - one debounced channel: synchroniser, stability counter, edge pulses
module module_debouncer_channel
    import debouncer_pkg::*;
#(
    parameter int   SYNC_STAGES   = DEB_SYNC_STAGES_DEF,
    parameter int   STABLE_CYCLES = DEB_STABLE_CYCLES_DEF,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sample_tick_i,
    input  logic debouncer_i,
    output logic debouncer_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("SYNC_STAGES must be >= 2");
        end
        if (STABLE_CYCLES < 1) begin : g_bad_stable
            $error("STABLE_CYCLES must be >= 1");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync_bit;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], debouncer_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Any return to the current output level throws away the partial count.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_bit == level_q) begin
            cnt_d = '0;
        end else if (sample_tick_i) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_bit;
                cnt_d   = '0;
                rise_d  = sync_bit;
                fall_d  = ~sync_bit;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    assign debouncer_o = level_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;

endmodule

// File: rtl/module_debouncer_multi.sv
// rtl/module_debouncer_multi.sv - multi-channel debouncer with aggregated change flag
module module_debouncer_multi
    import debouncer_pkg::*;
#(
    parameter int   CHANNELS      = 4,
    parameter int   SYNC_STAGES   = DEB_SYNC_STAGES_DEF,
    parameter int   STABLE_CYCLES = DEB_STABLE_CYCLES_DEF,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                sample_tick_i,
    input  logic [CHANNELS-1:0] debouncer_i,
    output logic [CHANNELS-1:0] debouncer_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic                changed_o
);

    generate
        if (CHANNELS < 1) begin : g_bad_channels
            $error("CHANNELS must be >= 1");
        end
    endgenerate

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        module_debouncer_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_LEVEL   (RESET_LEVEL)
        ) u_channel (
            .clk_i         (clk_i),
            .reset_i       (reset_i),
            .sample_tick_i (sample_tick_i),
            .debouncer_i   (debouncer_i[n]),
            .debouncer_o   (debouncer_o[n]),
            .rise_o        (rise_o[n]),
            .fall_o        (fall_o[n])
        );
    end

    // Pulses are already registered per channel, so the OR adds no latency.
    assign changed_o = |(rise_o | fall_o);

endmodule

// File: tb/tb_module_debouncer_multi.sv
// tb/tb_module_debouncer_multi.sv - scoreboard bench for module_debouncer_multi
module tb_module_debouncer_multi;

    logic       clk;
    logic       reset_i;
    logic       sample_tick_i;
    logic [3:0] din;
    logic [3:0] dout, rise, fall;
    logic       changed;

    int cycle = 0;
    int n_cmp = 0;
    int n_err = 0;
    logic tick_on  = 1'b1;
    logic tick_all = 1'b1;

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] lvl;
    } ev_t;
    ev_t q[$];

    module_debouncer_multi #(
        .CHANNELS      (4),
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (8),
        .RESET_LEVEL   (1'b0)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .sample_tick_i (sample_tick_i),
        .debouncer_i   (din),
        .debouncer_o   (dout),
        .rise_o        (rise),
        .fall_o        (fall),
        .changed_o     (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // In quarter mode the tick is high for edges whose number is a multiple of 4.
    assign sample_tick_i = tick_on & (tick_all | (((cycle + 1) % 4) == 0));

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input int dt, input logic [3:0] r, input logic [3:0] f,
                             input logic [3:0] l);
        ev_t e;
        e.cyc  = cycle + dt;
        e.rise = r;
        e.fall = f;
        e.lvl  = l;
        q.push_back(e);
    endtask

    task automatic drain();
        int budget = 200;
        while (q.size() != 0 && budget > 0) begin
            step(1);
            budget--;
        end
        if (q.size() != 0) begin
            check("drain_timeout", q.size(), 0);
            q.delete();
        end
        step(3);
    endtask

    always @(negedge clk) begin
        if (!reset_i) begin
            if (changed) begin
                if (q.size() == 0) begin
                    check("unexpected_event", 32'(rise | fall), 0);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    check("event_cycle", cycle, e.cyc);
                    check("rise_o", 32'(rise), 32'(e.rise));
                    check("fall_o", 32'(fall), 32'(e.fall));
                    check("debouncer_o", 32'(dout), 32'(e.lvl));
                end
            end else if (q.size() != 0 && q[0].cyc <= cycle) begin
                check("missed_event_cycle", cycle, q[0].cyc);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        reset_i = 1'b1;
        din     = 4'h0;
        step(2);
        check("reset_dout", 32'(dout), 0);
        check("reset_pulses", 32'({rise, fall, changed}), 0);

        // All channels high out of reset: full count from release.
        din = 4'hF;
        step(1);
        reset_i = 1'b0;
        expect_ev(10, 4'hF, 4'h0, 4'hF);
        drain();

        // Async reset clears outputs without waiting for a clock edge.
        @(posedge clk);
        #2;
        reset_i = 1'b1;
        #1;
        check("async_reset_dout", 32'(dout), 0);
        check("async_reset_changed", 32'(changed), 0);
        step(2);
        reset_i = 1'b0;
        expect_ev(10, 4'hF, 4'h0, 4'hF);
        drain();
        din = 4'h0;
        expect_ev(10, 4'h0, 4'hF, 4'h0);
        drain();

        // Clean edges on ch0.
        din = 4'b0001;
        expect_ev(10, 4'b0001, 4'h0, 4'b0001);
        drain();
        din = 4'b0000;
        expect_ev(10, 4'h0, 4'b0001, 4'b0000);
        drain();

        // Seven-cycle glitch on ch1 is one count short.
        din = 4'b0010;
        step(7);
        din = 4'b0000;
        step(20);
        check("glitch_dout", 32'(dout), 0);

        // Bounce 1,0,1,1,0 then steady 1.
        din = 4'b0010; step(1);
        din = 4'b0000; step(1);
        din = 4'b0010; step(1);
        din = 4'b0010; step(1);
        din = 4'b0000; step(1);
        din = 4'b0010;
        expect_ev(10, 4'b0010, 4'h0, 4'b0010);
        drain();
        din = 4'b0000;
        expect_ev(10, 4'h0, 4'b0010, 4'b0000);
        drain();

        // Tick 1 in 4 on ch2: eight ticked edges after the sync delay.
        tick_all = 1'b0;
        while ((cycle % 4) != 0) step(1);
        din = 4'b0100;
        expect_ev(32, 4'b0100, 4'h0, 4'b0100);
        drain();

        // Tick dropped for 20 clocks after three counts; count resumes.
        while ((cycle % 4) != 0) step(1);
        din = 4'b0000;
        expect_ev(52, 4'h0, 4'b0100, 4'b0000);
        step(12);
        tick_on = 1'b0;
        step(20);
        check("tick_hold_dout", 32'(dout), 32'(4'b0100));
        tick_on = 1'b1;
        drain();
        tick_all = 1'b1;

        // Simultaneous rise on ch0 and fall on ch3.
        din = 4'b1000;
        expect_ev(10, 4'b1000, 4'h0, 4'b1000);
        drain();
        din = 4'b0001;
        expect_ev(10, 4'b0001, 4'b1000, 4'b0001);
        drain();
        din = 4'b0000;
        expect_ev(10, 4'h0, 4'b0001, 4'b0000);
        drain();

        // Reset with ch1 counter at 5: no pulse, fresh count after release.
        din = 4'b0010;
        step(7);
        reset_i = 1'b1;
        #1;
        check("midcount_reset_dout", 32'(dout), 0);
        check("midcount_reset_rise", 32'(rise), 0);
        step(1);
        reset_i = 1'b0;
        expect_ev(10, 4'b0010, 4'h0, 4'b0010);
        drain();
        din = 4'b0000;
        expect_ev(10, 4'h0, 4'b0010, 4'b0000);
        drain();

        check("final_dout", 32'(dout), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
